// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, the MMIO address and the byte-lane helpers.
package dmem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        RESP = ST_RESP
    } state_t;

    localparam logic [31:0] MMIO_ADDR = 32'h0001_0000;

    // Zero-extended lane read (lbu semantics), lane 0 = bits [7:0].
    function automatic logic [31:0] byte_extract(input logic [31:0] word, input logic [1:0] lane);
        return {24'h0, word[8*lane +: 8]};
    endfunction

    // A byte store drives the byte on every lane; lane_mask picks the one that lands.
    function automatic logic [31:0] byte_merge(input logic [7:0] data);
        return {4{data}};
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data array: synchronous write with per-byte-lane enables,
// combinational read of the same word address.
module dmem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1 << DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-port memory responder with configurable wait states over valid/ready.
// Optional memory-mapped output register enabled by DMEM_RESPONDER_MMIO_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_write,
    input  logic                  req_byte,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
`ifdef DMEM_RESPONDER_MMIO_EN
    ,
    output logic [DATA_WIDTH-1:0] mmio_o
`endif
);

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t                  state;
    logic [3:0]              cnt;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    write_q;
    logic                    byte_q;

    logic                    exec;
    logic [DATA_WIDTH-1:0]   a_addr;
    logic [DATA_WIDTH-1:0]   a_wdata;
    logic                    a_write;
    logic                    a_byte;
    logic                    is_mmio;
    logic                    err_c;
    logic [DATA_WIDTH-1:0]   rdata_c;
    logic [3:0]              arr_we;
    logic [DATA_WIDTH-1:0]   arr_wdata;
    logic [DATA_WIDTH-1:0]   arr_rdata;
    logic                    addr_unused;

    // With zero wait states the access executes on the accept edge itself,
    // so the operands come straight from the request inputs in IDLE.
    always_comb begin
        exec    = (state == IDLE && req_valid && LATENCY == 0) ||
                  (state == WAIT && cnt == 4'd1);
        a_addr  = (state == IDLE) ? req_addr  : addr_q;
        a_wdata = (state == IDLE) ? req_wdata : wdata_q;
        a_write = (state == IDLE) ? req_write : write_q;
        a_byte  = (state == IDLE) ? req_byte  : byte_q;
    end

`ifdef DMEM_RESPONDER_MMIO_EN
    assign is_mmio = (a_addr == MMIO_ADDR);
`else
    assign is_mmio = 1'b0;
`endif

    always_comb begin
        err_c     = (!a_byte && a_addr[1:0] != 2'b00) || (is_mmio && a_byte);
        arr_we    = '0;
        arr_wdata = a_byte ? byte_merge(a_wdata[7:0]) : a_wdata;
        if (exec && a_write && !err_c && !is_mmio)
            arr_we = a_byte ? lane_mask(a_addr[1:0]) : 4'hF;
        rdata_c = '0;
        if (!err_c && !a_write) begin
`ifdef DMEM_RESPONDER_MMIO_EN
            if (is_mmio) rdata_c = mmio_o;
            else
`endif
            rdata_c = a_byte ? byte_extract(arr_rdata, a_addr[1:0]) : arr_rdata;
        end
    end

    assign addr_unused = ^a_addr[DATA_WIDTH-1:DEPTH_LOG2+2];

    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .addr (a_addr[DEPTH_LOG2+1:2]),
        .wdata(arr_wdata),
        .rdata(arr_rdata)
    );

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
`ifdef DMEM_RESPONDER_MMIO_EN
            mmio_o     <= '0;
`endif
        end else begin
`ifdef DMEM_RESPONDER_MMIO_EN
            if (exec && a_write && !err_c && is_mmio) mmio_o <= a_wdata;
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        write_q <= req_write;
                        byte_q  <= req_byte;
                        cnt     <= LAT;
                        if (LATENCY == 0) begin
                            state      <= RESP;
                            resp_rdata <= rdata_c;
                            resp_err   <= err_c;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state      <= RESP;
                        cnt        <= '0;
                        resp_rdata <= rdata_c;
                        resp_err   <= err_c;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: one instance with two wait
// states and one with zero, sharing the request bus and the reset.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        v2, v0;
    logic        rdy2, rdy0;
    logic [31:0] req_addr, req_wdata;
    logic        req_write, req_byte;
    logic        rv2, rv0;
    logic        resp_ready;
    logic [31:0] rd2, rd0;
    logic        er2, er0;
`ifdef DMEM_RESPONDER_MMIO_EN
    logic [31:0] mmio2, mmio0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write), .req_byte(req_byte),
        .resp_valid(rv2), .resp_ready(resp_ready), .resp_rdata(rd2), .resp_err(er2)
`ifdef DMEM_RESPONDER_MMIO_EN
        , .mmio_o(mmio2)
`endif
    );

    dmem_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write), .req_byte(req_byte),
        .resp_valid(rv0), .resp_ready(resp_ready), .resp_rdata(rd0), .resp_err(er0)
`ifdef DMEM_RESPONDER_MMIO_EN
        , .mmio_o(mmio0)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request, then scrambles the bus so only the accept edge matters.
    task automatic issue(input bit zero_lat, input logic [31:0] a, input logic [31:0] wd,
                         input logic w, input logic b, output int lat);
        req_addr = a; req_wdata = wd; req_write = w; req_byte = b;
        if (zero_lat) v0 = 1'b1; else v2 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0; v2 = 1'b0;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_write = ~w; req_byte = ~b;
        lat = 1;
        while (!(zero_lat ? rv0 : rv2) && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic txn(input string tag, input bit zero_lat, input logic [31:0] a,
                       input logic [31:0] wd, input logic w, input logic b,
                       input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        issue(zero_lat, a, wd, w, b, lat);
        check({tag, "_lat"}, lat, zero_lat ? 32'd1 : 32'd3);
        check({tag, "_rdata"}, zero_lat ? rd0 : rd2, exp_rd);
        check({tag, "_err"}, {31'b0, zero_lat ? er0 : er2}, {31'b0, exp_err});
        release_resp();
        check({tag, "_idle"}, {30'b0, zero_lat ? rdy0 : rdy2, zero_lat ? rv0 : rv2}, 32'h2);
    endtask

    initial begin
        int lat;
        rst = 1'b0; v2 = 1'b0; v0 = 1'b0; resp_ready = 1'b0;
        req_addr = '0; req_wdata = '0; req_write = 1'b0; req_byte = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, rdy2}, 32'h1);
        check("rst_valid", {31'b0, rv2}, 32'h0);
        check("rst_rdata", rd2, 32'h0);
        check("rst_err", {31'b0, er2}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        txn("st_word", 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0);
        txn("ld_word", 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);

        txn("st_base", 1'b0, 32'h10, 32'h11223344, 1'b1, 1'b0, 32'h0, 1'b0);
        txn("st_byte", 1'b0, 32'h13, 32'h123456AA, 1'b1, 1'b1, 32'h0, 1'b0);
        txn("ld_merged", 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'hAA223344, 1'b0);
        txn("ld_byte3", 1'b0, 32'h13, 32'h0, 1'b0, 1'b1, 32'h000000AA, 1'b0);
        txn("ld_byte1", 1'b0, 32'h11, 32'h0, 1'b0, 1'b1, 32'h00000033, 1'b0);

        txn("ld_misal", 1'b0, 32'h12, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        txn("st_misal", 1'b0, 32'h12, 32'h55, 1'b1, 1'b0, 32'h0, 1'b1);
        txn("ld_after_misal", 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'hAA223344, 1'b0);
        txn("ld_alias", 1'b0, 32'h0000_1010, 32'h0, 1'b0, 1'b0, 32'hAA223344, 1'b0);

        // Backpressure: response must hold steady while resp_ready is low.
        issue(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, lat);
        check("hold_lat", lat, 32'd3);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'b0, rv2}, 32'h1);
            check("hold_rdata", rd2, 32'hAA223344);
            check("hold_err", {31'b0, er2}, 32'h0);
            check("hold_ready", {31'b0, rdy2}, 32'h0);
            @(posedge clk); #1;
        end
        release_resp();
        check("hold_release_ready", {31'b0, rdy2}, 32'h1);
        check("hold_release_valid", {31'b0, rv2}, 32'h0);
        check("hold_release_rdata", rd2, 32'h0);

        // Reset during WAIT drops the uncommitted store.
        txn("st_prior", 1'b0, 32'h20, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0, 1'b0);
        req_addr = 32'h20; req_wdata = 32'h1; req_write = 1'b1; req_byte = 1'b0; v2 = 1'b1;
        @(posedge clk); #1;
        v2 = 1'b0;
        check("wait_ready", {31'b0, rdy2}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("midrst_ready", {31'b0, rdy2}, 32'h1);
        check("midrst_valid", {31'b0, rv2}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_still_idle", {31'b0, rv2}, 32'h0);
        txn("ld_discarded", 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0);

        txn("z_st", 1'b1, 32'h4, 32'h12345678, 1'b1, 1'b0, 32'h0, 1'b0);
        txn("z_ld", 1'b1, 32'h4, 32'h0, 1'b0, 1'b0, 32'h12345678, 1'b0);
        txn("z_ld_byte", 1'b1, 32'h7, 32'h0, 1'b0, 1'b1, 32'h00000012, 1'b0);
        txn("z_misal", 1'b1, 32'h5, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
